fp_mult_arbiter: RTL
====================

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_REQ, default 4: number of requesters.
- DATA_W, default 32: IEEE-754 single-precision operand width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-005 req_a  input  N_REQ*DATA_W  operand A, requester i at bits [i*32+:32].
REQ-006 req_b  input  N_REQ*DATA_W  operand B, same packing as req_a.
REQ-007 req_ready  output  N_REQ  one-hot grant; a pair transfers when req_valid[i] & req_ready[i].
REQ-008 out_valid  output  1  product register holds an undelivered result.
REQ-009 out_data  output  DATA_W  FP32 product.
REQ-010 out_id  output  log2(N_REQ)  index of the requester that owns out_data.
REQ-011 out_ready  input  1  consumer accepts the result when out_valid & out_ready.

Function
REQ-012 Exactly one shared FP32 multiplier SHALL be used; at most one pair SHALL be accepted per cycle.
REQ-013 Grant SHALL be round-robin over the requesters with req_valid high:
- Search starts at pointer ptr.
- After a grant to index i, ptr SHALL become (i+1) mod N_REQ.
- ptr SHALL be unchanged in cycles with no grant.
REQ-014 req_ready SHALL be combinational from req_valid, ptr and slot state.
- req_ready SHALL be all-zero unless out_valid==0 or out_ready==1.
- req_ready SHALL never assert for a requester whose req_valid is low.
REQ-015 Latency SHALL be 1 cycle: for a pair accepted in cycle N, out_valid=1 with the product and out_id in cycle N+1.
REQ-016 While out_valid==1 and out_ready==0, out_data and out_id SHALL hold stable and no grant SHALL occur.
REQ-017 On a simultaneous drain and new grant in the same cycle, the slot SHALL reload with the new result and out_valid SHALL stay 1 (no bubble).
REQ-018 On a drain with no grant, out_valid SHALL fall to 0 on the next edge.
REQ-019 Product arithmetic SHALL be that of the team multiplier:
- sign = XOR of the operand signs; 24x24 mantissa product, truncated (no rounding).
- Exponent = EA+EB-127, or +1 when the product MSB is set.
- Any operand with bits[30:0]==0 SHALL give 32'h00000000.
- No NaN/Inf/denormal handling and no overflow saturation.
REQ-020 Requesters SHALL hold req_a/req_b stable while req_valid is high and ungranted; the block SHALL not latch operands before grant.
REQ-021 With all req_valid low, the block SHALL idle: no ptr change, slot drains normally.

Reset
REQ-022 While rst is high at a clock edge, the following SHALL apply on that edge:
- out_valid=0, out_data=0, out_id=0, ptr=0.
- req_ready SHALL be all-zero during any cycle in which rst is high.
REQ-023 Reset asserted mid-operation SHALL discard the pending result without delivering it.
REQ-024 After rst deasserts, requester 0 SHALL have first priority.

Structure
REQ-025 A shared package SHALL hold the FP32 field widths (sign 1, exponent 8, mantissa 23), the exponent bias 127, N_REQ and the id width.
REQ-026 The multiplier SHALL be instantiated as the sub-module multiplier (purely combinational) between the grant mux and the output register.
REQ-027 The round-robin selector SHALL be a local function or always block; no further sub-modules.

Verification
REQ-028 Single request: requester 2 sends 0x40000000 x 0x40400000, out_ready=1 -> next cycle out_valid=1, out_data=0x40C00000, out_id=2.
REQ-029 All four valid every cycle, out_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; out_id matches the grant order.
REQ-030 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> req_ready all-zero and out_data stable; first cycle with out_ready=1 -> new grant and reload with no bubble.
REQ-031 Arithmetic corners:
- 0x3FC00000 x 0x3FC00000 -> 0x40100000.
- 0xBF800000 x 0x40000000 -> 0xC0000000.
- 0x00000000 x 0x40400000 -> 0x00000000.
- 0x80000000 x 0x3F800000 -> 0x00000000.
REQ-032 Reset mid-operation: rst pulsed for 1 cycle while out_valid=1 -> out_valid=0, ptr=0, no delivery of the old result; requester 0 is granted first afterwards.

Source files
------------

// File: rtl/fp_mult_arbiter_pkg.sv
// Shared definitions for the FP32 multiplier arbiter: field widths,
// exponent bias, requester count and the FP32 field view.
package fp_mult_arbiter_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int FP_W     = SIGN_W + EXP_W + MAN_W;
  localparam int EXP_BIAS = 127;

  localparam int N_REQ = 4;
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_mult_arbiter_multiplier.sv
// Combinational FP32 multiplier: truncated 24x24 significand product,
// single-step normalisation, zero forced when either operand magnitude is 0.
// No NaN/Inf/denormal handling; the exponent simply wraps on overflow.
module multiplier
  import fp_mult_arbiter_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] p
);

  fp32_t              fa;
  fp32_t              fb;
  fp32_t              fr;
  logic [MAN_W:0]     sig_a;
  logic [MAN_W:0]     sig_b;
  logic [2*MAN_W+1:0] sig_prod;
  logic [EXP_W-1:0]   exp_base;
  logic               unused_low_bits;

  // Multiply significands, pick the normalised window and fix up the exponent
  always_comb begin
    fa       = a;
    fb       = b;
    sig_a    = {1'b1, fa.man};
    sig_b    = {1'b1, fb.man};
    sig_prod = sig_a * sig_b;
    exp_base = fa.exp + fb.exp - EXP_W'(EXP_BIAS);
    fr.sign  = fa.sign ^ fb.sign;
    if (sig_prod[2*MAN_W+1]) begin
      fr.exp = exp_base + 1'b1;
      fr.man = sig_prod[2*MAN_W:MAN_W+1];
    end else begin
      fr.exp = exp_base;
      fr.man = sig_prod[2*MAN_W-1:MAN_W];
    end
    if ((a[FP_W-2:0] == '0) || (b[FP_W-2:0] == '0)) begin
      fr = '0;
    end
    p = fr;
  end

  assign unused_low_bits = ^sig_prod[MAN_W-1:0];

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier among N_REQ requesters.
// One pair is accepted per cycle; the product lands in a single output
// slot one cycle later and is held there until the consumer takes it.
module fp_mult_arbiter #(
  parameter  int N_REQ  = fp_mult_arbiter_pkg::N_REQ,
  parameter  int DATA_W = fp_mult_arbiter_pkg::FP_W,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDW-1:0]          out_id,
  input  logic                    out_ready
);

  import fp_mult_arbiter_pkg::*;

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]    out_id_q, out_id_d;

  logic              can_grant;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    cand;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] op_a, op_b, product;

  // Round-robin search from ptr; grant only when the slot is free or draining
  always_comb begin
    can_grant = !rst && (!out_valid_q || out_ready);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    grant = '0;
    if (can_grant && gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign op_a = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign op_b = req_b[int'(gnt_idx)*DATA_W +: DATA_W];

  multiplier u_mult (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  // Slot update: reload on grant (even while draining), empty on drain alone
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (grant != '0) begin
      out_valid_d = 1'b1;
      out_data_d  = product;
      out_id_d    = gnt_idx;
      ptr_d       = IDW'((int'(gnt_idx) + 1) % N_REQ);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending result and restarts at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign req_ready = grant;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
